// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the uart_alu_proc packet ALU stage.
// Multiply support is selected by UART_ALU_MUL_EN in the files that use this package.
package uart_alu_pkg;

    typedef enum logic [2:0] {
        StOpcode,
        StRsv,
        StLenLo,
        StLenHi,
        StEcho,
        StOperand,
        StDrain,
        StResult
    } state_e;

    localparam logic [7:0]  OpEcho      = 8'hEC;
    localparam logic [7:0]  OpAdd       = 8'hAD;
    localparam logic [7:0]  OpMul       = 8'h88;
    localparam logic [15:0] HeaderBytes = 16'd4;

    // Lengths shorter than the header behave as a header-only packet.
    function automatic logic [15:0] payload_len(input logic [15:0] total_len);
        if (total_len < HeaderBytes) begin
            return 16'd0;
        end
        return total_len - HeaderBytes;
    endfunction

endpackage

// File: rtl/uart_alu_acc32.sv
// 32-bit accumulator: assembles little-endian operand words and folds them with add or multiply.
// The multiplier exists only when UART_ALU_MUL_EN is defined.
module alu_acc32
    import uart_alu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        step_i,
    input  logic        first_i,
    input  logic        op_mul_i,
    input  logic [7:0]  data_i,
    output logic [31:0] acc_o,
    output logic        word_done_o
);

    logic [1:0]  lane_q;
    logic [23:0] word_q;
    logic [31:0] acc_q;
    logic [31:0] word;
    logic [31:0] folded;

    assign word        = {data_i, word_q};
    assign word_done_o = step_i && (lane_q == 2'd3);
    assign acc_o       = acc_q;

`ifdef UART_ALU_MUL_EN
    always_comb begin
        folded = acc_q + word;
        if (op_mul_i) begin
            folded = acc_q * word;
        end
    end
`else
    logic unused_op_mul;
    assign unused_op_mul = op_mul_i;

    always_comb begin
        folded = acc_q + word;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lane_q <= 2'd0;
            word_q <= 24'd0;
            acc_q  <= 32'd0;
        end else if (load_i) begin
            lane_q <= 2'd0;
            acc_q  <= 32'd0;
        end else if (step_i) begin
            lane_q <= lane_q + 2'd1;
            case (lane_q)
                2'd0:    word_q[7:0]   <= data_i;
                2'd1:    word_q[15:8]  <= data_i;
                2'd2:    word_q[23:16] <= data_i;
                default: acc_q         <= first_i ? word : folded;
            endcase
        end
    end

endmodule

// File: rtl/uart_alu_proc.sv
// Packet ALU between UART rx and tx: parses a 4-byte header, then echoes, drains or reduces the payload.
// Define UART_ALU_MUL_EN to decode opcode 0x88 as mul32.
//
// state     | meaning
// StOpcode  | waiting for opcode byte
// StRsv     | skipping reserved byte
// StLenLo   | capturing length LSB
// StLenHi   | capturing length MSB, choosing payload handling
// StEcho    | forwarding payload bytes through a one-deep tx buffer
// StOperand | folding payload words into the accumulator
// StDrain   | discarding payload of an unknown opcode
// StResult  | sending the four accumulator bytes, LSB first
module uart_alu_proc #(
    parameter int datawidth_p = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [datawidth_p-1:0] rx_data_i,
    input  logic                   rx_valid_i,
    output logic                   rx_ready_o,
    output logic [datawidth_p-1:0] tx_data_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i
);
    import uart_alu_pkg::*;

    state_e                 state_q, state_d;
    logic                   rx_ready_q, rx_ready_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [datawidth_p-1:0] tx_data_q, tx_data_d;
    logic [15:0]            remaining_q, remaining_d;
    logic [7:0]             opcode_q, opcode_d;
    logic [7:0]             len_lo_q, len_lo_d;
    logic [1:0]             res_idx_q, res_idx_d;
    logic                   first_q;
    logic [15:0]            pay_len;
    logic                   rx_fire, tx_fire;
    logic                   is_echo, is_mul, is_arith;
    logic                   acc_load, acc_step, word_done;
    logic [31:0]            acc;
    logic [7:0]             result_byte;

    assign rx_fire = rx_valid_i && rx_ready_q;
    assign tx_fire = tx_valid_q && tx_ready_i;

    assign is_echo = (opcode_q == OpEcho);
`ifdef UART_ALU_MUL_EN
    assign is_mul = (opcode_q == OpMul);
`else
    assign is_mul = 1'b0;
`endif
    assign is_arith = (opcode_q == OpAdd) || is_mul;

    alu_acc32 u_acc (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (acc_load),
        .step_i      (acc_step),
        .first_i     (first_q),
        .op_mul_i    (is_mul),
        .data_i      (rx_data_i),
        .acc_o       (acc),
        .word_done_o (word_done)
    );

    always_comb begin
        state_d     = state_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        remaining_d = remaining_q;
        opcode_d    = opcode_q;
        len_lo_d    = len_lo_q;
        res_idx_d   = res_idx_q;
        acc_load    = 1'b0;
        acc_step    = 1'b0;
        pay_len     = payload_len({rx_data_i, len_lo_q});

        case (state_q)
            StOpcode: begin
                if (rx_fire) begin
                    opcode_d = rx_data_i;
                    state_d  = StRsv;
                end
            end
            StRsv: begin
                if (rx_fire) begin
                    state_d = StLenLo;
                end
            end
            StLenLo: begin
                if (rx_fire) begin
                    len_lo_d = rx_data_i;
                    state_d  = StLenHi;
                end
            end
            StLenHi: begin
                if (rx_fire) begin
                    remaining_d = pay_len;
                    acc_load    = 1'b1;
                    res_idx_d   = 2'd0;
                    if (pay_len == 16'd0) begin
                        if (is_arith) begin
                            state_d    = StResult;
                            tx_valid_d = 1'b1;
                        end else begin
                            state_d = StOpcode;
                        end
                    end else if (is_echo) begin
                        state_d = StEcho;
                    end else if (is_arith) begin
                        state_d = StOperand;
                    end else begin
                        state_d = StDrain;
                    end
                end
            end
            StEcho: begin
                // rx is only ready while the tx buffer is empty, so both never fire together
                if (rx_fire) begin
                    tx_data_d   = rx_data_i;
                    tx_valid_d  = 1'b1;
                    remaining_d = remaining_q - 16'd1;
                end else if (tx_fire) begin
                    tx_valid_d = 1'b0;
                    if (remaining_q == 16'd0) begin
                        state_d = StOpcode;
                    end
                end
            end
            StOperand: begin
                if (rx_fire) begin
                    acc_step    = 1'b1;
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d    = StResult;
                        tx_valid_d = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (rx_fire) begin
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d = StOpcode;
                    end
                end
            end
            StResult: begin
                if (tx_fire) begin
                    if (res_idx_q == 2'd3) begin
                        tx_valid_d = 1'b0;
                        state_d    = StOpcode;
                    end else begin
                        res_idx_d = res_idx_q + 2'd1;
                    end
                end
            end
            default: state_d = StOpcode;
        endcase
    end

    // Ready is registered from the upcoming state so it never depends on inputs combinationally.
    always_comb begin
        rx_ready_d = 1'b1;
        case (state_d)
            StEcho:   rx_ready_d = !tx_valid_d;
            StResult: rx_ready_d = 1'b0;
            default:  rx_ready_d = 1'b1;
        endcase
    end

    always_comb begin
        result_byte = acc[7:0];
        case (res_idx_q)
            2'd1:    result_byte = acc[15:8];
            2'd2:    result_byte = acc[23:16];
            2'd3:    result_byte = acc[31:24];
            default: result_byte = acc[7:0];
        endcase
    end

    assign tx_data_o  = (state_q == StResult) ? result_byte : tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign rx_ready_o = rx_ready_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StOpcode;
            rx_ready_q  <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            remaining_q <= 16'd0;
            opcode_q    <= 8'd0;
            len_lo_q    <= 8'd0;
            res_idx_q   <= 2'd0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_ready_q  <= rx_ready_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            remaining_q <= remaining_d;
            opcode_q    <= opcode_d;
            len_lo_q    <= len_lo_d;
            res_idx_q   <= res_idx_d;
            if (acc_load) begin
                first_q <= 1'b1;
            end else if (word_done) begin
                first_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_alu_proc.sv
// Self-checking bench for uart_alu_proc: directed vector table, corner sequences and random packets.
// Honours UART_ALU_MUL_EN the same way as the design.
module tb_uart_alu_proc;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        string          name;
        logic [127:0]   pkt;
        int             plen;
        logic [63:0]    exp;
        int             elen;
    } vec_t;

`ifdef UART_ALU_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic       rx_ready_o;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;

    uart_alu_proc #(.datawidth_p(8)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   overlap_cnt = 0;
    bit   tx_rand = 1'b0;
    bit   tx_force = 1'b1;
    bq_t  got;
    int   got_cyc[$];
    vec_t vecs[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    // Drives tx_ready, then records every handshake that will complete on the next rising edge.
    always begin
        @(negedge clk_i);
        tx_ready_i = tx_rand ? ($urandom_range(0, 3) != 0) : tx_force;
        #1;
        if (!rst_i && tx_valid_o && tx_ready_i) begin
            got.push_back(tx_data_o);
            got_cyc.push_back(cyc);
        end
        if (!rst_i && tx_valid_o && rx_ready_o) overlap_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit accepted = 1'b0;
        bit rdy;
        if (gaps) begin
            rx_valid_i = 1'b0;
            rx_data_i  = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        for (int n = 0; n < 300 && !accepted; n++) begin
            rdy = rx_ready_o;
            @(posedge clk_i);
            if (rdy) accepted = 1'b1;
            @(negedge clk_i);
        end
        rx_valid_i = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL rx_accept_timeout: byte %0h not accepted", b);
        end
    endtask

    task automatic send_pkt(input bq_t p, input bit gaps);
        foreach (p[i]) send_byte(p[i], gaps);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int n = 0; n < 2000 && !idle; n++) begin
            if (rx_ready_o && !tx_valid_o) idle = 1'b1;
            else @(negedge clk_i);
        end
        if (!idle) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: rx_ready=%0b tx_valid=%0b", rx_ready_o, tx_valid_o);
        end
    endtask

    task automatic compare_q(input string name, input bq_t e);
        check({name, " count"}, 32'(got.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < got.size(); i++)
            check($sformatf("%s byte%0d", name, i), {24'd0, got[i]}, {24'd0, e[i]});
    endtask

    // Reference: parse the header and compute the output from packet-level rules.
    task automatic model(input bq_t p, output bq_t e);
        logic [7:0]  op;
        logic [15:0] len;
        int          pl, nwords;
        logic [31:0] r, w;
        e = {};
        op  = p[0];
        len = {p[3], p[2]};
        pl  = (len < 16'd4) ? 0 : int'(len) - 4;
        if (op == 8'hEC) begin
            for (int i = 0; i < pl; i++) e.push_back(p[4 + i]);
        end else if (op == 8'hAD || (MulEn && op == 8'h88)) begin
            r = 32'd0;
            nwords = pl / 4;
            for (int k = 0; k < nwords; k++) begin
                w = {p[4 + 4*k + 3], p[4 + 4*k + 2], p[4 + 4*k + 1], p[4 + 4*k]};
                if (k == 0)           r = w;
                else if (op == 8'hAD) r = r + w;
                else                  r = r * w;
            end
            for (int k = 0; k < 4; k++) e.push_back(r[8*k +: 8]);
        end
    endtask

    task automatic add_vec(input string name, input logic [127:0] pkt, input int plen,
                           input logic [63:0] expv, input int elen);
        vec_t v;
        v.name = name; v.pkt = pkt; v.plen = plen; v.exp = expv; v.elen = elen;
        vecs.push_back(v);
    endtask

    initial begin
        bq_t        p, e;
        logic [7:0] snap_data;
        bit         stable;
        logic [7:0] op;
        logic [15:0] len;
        int         pl;

        rst_i      = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'd0;
        tx_ready_i = 1'b1;

        add_vec("add",         128'hAD000C00_01000000_02000000, 12, 64'h03000000, 4);
        add_vec("add_ovf",     128'hAD000C00_FFFFFFFF_02000000, 12, 64'h01000000, 4);
        if (MulEn) add_vec("mul", 128'h88000C00_03000000_05000000, 12, 64'h0F000000, 4);
        else       add_vec("mul", 128'h88000C00_03000000_05000000, 12, 64'h0,       0);
        add_vec("add_after",   128'hAD000C00_01000000_02000000, 12, 64'h03000000, 4);
        add_vec("echo",        128'hEC000700_414243,             7, 64'h414243,   3);
        add_vec("drain",       128'h55000600_AABB,               6, 64'h0,        0);
        add_vec("add_empty",   128'hAD000400,                    4, 64'h00000000, 4);
        add_vec("echo_len2",   128'hEC000200,                    4, 64'h0,        0);
        add_vec("add_len3",    128'hAD000300,                    4, 64'h00000000, 4);
        add_vec("add_partial", 128'hAD000E00_01000000_02000000_7788, 14, 64'h03000000, 4);
        add_vec("add_three",   128'hAD001000_10000000_20000000_30000000, 16, 64'h60000000, 4);

        repeat (3) @(negedge clk_i);
        check("reset rx_ready", {31'd0, rx_ready_o}, 32'd0);
        check("reset tx_valid", {31'd0, tx_valid_o}, 32'd0);
        check("reset tx_data",  {24'd0, tx_data_o},  32'd0);
        rst_i = 1'b0;
        #1;
        check("rx_ready before first edge", {31'd0, rx_ready_o}, 32'd0);
        @(negedge clk_i);
        check("rx_ready after reset", {31'd0, rx_ready_o}, 32'd1);

        foreach (vecs[vi]) begin
            p = {};
            e = {};
            for (int i = 0; i < vecs[vi].plen; i++) p.push_back(vecs[vi].pkt[8*(vecs[vi].plen-1-i) +: 8]);
            for (int i = 0; i < vecs[vi].elen; i++) e.push_back(vecs[vi].exp[8*(vecs[vi].elen-1-i) +: 8]);
            got.delete();
            got_cyc.delete();
            send_pkt(p, 1'b0);
            wait_idle();
            compare_q(vecs[vi].name, e);
            check({vecs[vi].name, " rx_ready after"}, {31'd0, rx_ready_o}, 32'd1);
        end

        // Echo: tx_valid follows the accepted byte by one cycle and blocks rx while held.
        tx_force = 1'b0;
        repeat (2) @(negedge clk_i);
        got.delete();
        got_cyc.delete();
        p = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h41};
        send_pkt(p, 1'b0);
        check("echo tx_valid next cycle", {31'd0, tx_valid_o}, 32'd1);
        check("echo tx_data next cycle",  {24'd0, tx_data_o},  32'h41);
        check("echo rx_ready blocked",    {31'd0, rx_ready_o}, 32'd0);
        tx_force = 1'b1;
        wait_idle();
        compare_q("echo_one", '{8'h41});

        // Backpressure in StResult: outputs hold, then the rest stream back to back.
        tx_force = 1'b0;
        repeat (2) @(negedge clk_i);
        got.delete();
        got_cyc.delete();
        p = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h10, 8'h20, 8'h30, 8'h40};
        send_pkt(p, 1'b0);
        check("result tx_valid next cycle", {31'd0, tx_valid_o}, 32'd1);
        snap_data = tx_data_o;
        check("result first byte", {24'd0, snap_data}, 32'h14);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (tx_data_o !== snap_data || tx_valid_o !== 1'b1 || rx_ready_o !== 1'b0) stable = 1'b0;
        end
        check("backpressure hold", {31'd0, stable}, 32'd1);
        tx_force = 1'b1;
        wait_idle();
        compare_q("backpressure", '{8'h14, 8'h23, 8'h32, 8'h41});
        if (got_cyc.size() == 4)
            check("backpressure no bubble", 32'(got_cyc[3] - got_cyc[0]), 32'd3);
        check("backpressure rx_ready after", {31'd0, rx_ready_o}, 32'd1);

        // Reset in the middle of an add packet.
        got.delete();
        got_cyc.delete();
        p = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00};
        send_pkt(p, 1'b0);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("midreset tx_valid", {31'd0, tx_valid_o}, 32'd0);
        check("midreset tx_data",  {24'd0, tx_data_o},  32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        p = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00};
        send_pkt(p, 1'b0);
        wait_idle();
        compare_q("after midreset", '{8'h0B, 8'h00, 8'h00, 8'h00});

        // Random packets with rx gaps and random tx backpressure.
        tx_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       op = 8'hEC;
                1:       op = 8'hAD;
                2:       op = 8'h88;
                default: op = 8'($urandom_range(0, 255));
            endcase
            len = 16'($urandom_range(0, 26));
            pl  = (len < 16'd4) ? 0 : int'(len) - 4;
            p = '{op, 8'($urandom_range(0, 255)), len[7:0], len[15:8]};
            for (int i = 0; i < pl; i++) p.push_back(8'($urandom_range(0, 255)));
            model(p, e);
            got.delete();
            got_cyc.delete();
            send_pkt(p, 1'b1);
            wait_idle();
            compare_q($sformatf("rand%0d op%0h len%0d", n, op, len), e);
        end
        tx_rand = 1'b0;

        check("rx_ready/tx_valid overlap", 32'(overlap_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
